// File: rtl/z_pkg.sv
// Shared definitions for the Z result-capture stage: widths, entry layout
// and the beat FSM encoding.
package z_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned OP_W  = 4;

  typedef enum logic {
    BEAT_LO = 1'b0,
    BEAT_HI = 1'b1
  } beat_e;

  // Canonical entry layout at the default width; the top mirrors this order.
  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             wide;
    logic [OP_W-1:0]  op;
    logic             zero;
    logic             neg;
  } entry_t;

  // Packed bit count of one entry for a given datapath width.
  function automatic int unsigned entry_w(input int unsigned width);
    return 2 * width + 1 + OP_W + 2;
  endfunction

endpackage

// File: rtl/z_entry_fifo.sv
// DEPTH-entry register FIFO with push/pop, occupancy count and async
// active-low reset; head entry is presented combinationally on rdata.
module z_entry_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned EW    = 8,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          push,
  input  logic          pop,
  input  logic [EW-1:0] wdata,
  output logic [EW-1:0] rdata,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Guard against overflow/underflow so the count can never leave 0..DEPTH.
  assign push_ok = push && (count != CW'(DEPTH));
  assign pop_ok  = pop  && (count != CW'(0));
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/z_result_stage.sv
// Captures operator Z results (narrow or 64-bit wide), tags them with
// zero/negative flags and streams them onto the bus as one or two beats.
module z_result_stage
  import z_pkg::*;
#(
  parameter int unsigned WIDTH = z_pkg::WIDTH,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_lo,
  input  logic [WIDTH-1:0] in_hi,
  input  logic             in_wide,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             out_hi,
  output logic             out_zero,
  output logic             out_neg,
  output logic [OP_W-1:0]  out_op
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned EW = entry_w(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             wide;
    logic [OP_W-1:0]  op;
    logic             zero;
    logic             neg;
  } z_entry_t;

  z_entry_t      wr_entry;
  z_entry_t      head;
  logic [EW-1:0] head_bits;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  beat_e         state;
  beat_e         state_nx;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != CW'(0));
  assign push      = in_valid && in_ready;
  assign head      = z_entry_t'(head_bits);

  // Flag computation on the incoming result; narrow results ignore in_hi.
  always_comb begin
    wr_entry      = '0;
    wr_entry.lo   = in_lo;
    wr_entry.hi   = in_wide ? in_hi : '0;
    wr_entry.wide = in_wide;
    wr_entry.op   = in_op;
    if (in_wide) begin
      wr_entry.zero = ({in_hi, in_lo} == '0);
      wr_entry.neg  = in_hi[WIDTH-1];
    end else begin
      wr_entry.zero = (in_lo == '0);
      wr_entry.neg  = in_lo[WIDTH-1];
    end
  end

  z_entry_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clk   (clk),
    .clr_n (clr_n),
    .push  (push),
    .pop   (pop),
    .wdata (EW'(wr_entry)),
    .rdata (head_bits),
    .count (count)
  );

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= BEAT_LO;
    end else begin
      state <= state_nx;
    end
  end

  // Beat sequencing; outputs are driven only while a result is held.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    out_data = '0;
    out_last = 1'b0;
    out_hi   = 1'b0;
    out_zero = 1'b0;
    out_neg  = 1'b0;
    out_op   = '0;
    if (out_valid) begin
      out_zero = head.zero;
      out_neg  = head.neg;
      out_op   = head.op;
      case (state)
        BEAT_LO: begin
          out_data = head.lo;
          out_last = !head.wide;
          if (out_ready) begin
            if (head.wide) begin
              state_nx = BEAT_HI;
            end else begin
              pop = 1'b1;
            end
          end
        end
        BEAT_HI: begin
          out_data = head.hi;
          out_hi   = 1'b1;
          out_last = 1'b1;
          if (out_ready) begin
            state_nx = BEAT_LO;
            pop      = 1'b1;
          end
        end
        default: state_nx = BEAT_LO;
      endcase
    end
  end

endmodule

// File: tb/tb_z_result_stage.sv
// Scoreboard bench for z_result_stage: directed pushes enqueue expected
// beats; a negedge monitor compares every beat the bus consumes.
module tb_z_result_stage;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        hi;
    logic        zero;
    logic        neg;
    logic [3:0]  op;
  } beat_t;

  logic        clk;
  logic        clr_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_lo;
  logic [31:0] in_hi;
  logic        in_wide;
  logic [3:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        out_hi;
  logic        out_zero;
  logic        out_neg;
  logic [3:0]  out_op;

  int    checks = 0;
  int    errors = 0;
  beat_t sb[$];

  z_result_stage #(.WIDTH(32), .DEPTH(2)) dut (
    .clk       (clk),
    .clr_n     (clr_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_lo     (in_lo),
    .in_hi     (in_hi),
    .in_wide   (in_wide),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_hi    (out_hi),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_op    (out_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every beat taken by the bus must match the scoreboard head.
  always @(negedge clk) begin
    if (clr_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data 0x%08h with empty scoreboard", out_data);
      end else begin
        beat_t e;
        beat_t a;
        e = sb.pop_front();
        a = '{data: out_data, last: out_last, hi: out_hi, zero: out_zero,
              neg: out_neg, op: out_op};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL beat: got d=%08h l=%0b h=%0b z=%0b n=%0b op=%0d expected d=%08h l=%0b h=%0b z=%0b n=%0b op=%0d",
                   a.data, a.last, a.hi, a.zero, a.neg, a.op,
                   e.data, e.last, e.hi, e.zero, e.neg, e.op);
        end
      end
    end
  end

  // Called just after a posedge; returns after the accepting edge (+1).
  task automatic push_res(input logic [31:0] lo, input logic [31:0] hi, input logic wide,
                          input logic [3:0] op, input logic ez, input logic en,
                          output int waits);
    bit ok;
    waits = 0;
    ok = 0;
    in_lo = lo; in_hi = hi; in_wide = wide; in_op = op; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      waits++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: in_ready stayed 0 expected 1 within 50 cycles");
    end
    @(posedge clk);
    if (ok) begin
      if (wide) begin
        sb.push_back('{data: lo, last: 1'b0, hi: 1'b0, zero: ez, neg: en, op: op});
        sb.push_back('{data: hi, last: 1'b1, hi: 1'b1, zero: ez, neg: en, op: op});
      end else begin
        sb.push_back('{data: lo, last: 1'b1, hi: 1'b0, zero: ez, neg: en, op: op});
      end
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int w;
    clr_n = 1'b0; in_valid = 1'b0; in_lo = '0; in_hi = '0; in_wide = 1'b0;
    in_op = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bits", {out_data}, 32'd0);
    chk("rst_out_flags", 32'({out_last, out_hi, out_zero, out_neg, out_op}), 32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    @(posedge clk); #1;

    // Narrow zero result with one-cycle latency
    out_ready = 1'b1;
    push_res(32'h0000_0000, 32'h0, 1'b0, 4'd3, 1'b1, 1'b0, w);
    chk("narrow_latency_valid", 32'(out_valid), 32'd1);
    drain();

    // Wide negative result, two consecutive beats
    push_res(32'h1234_5678, 32'h8000_0001, 1'b1, 4'd5, 1'b0, 1'b1, w);
    chk("wide_beat1_hi", 32'(out_hi), 32'd0);
    @(posedge clk); #1;
    chk("wide_beat2_hi", 32'(out_hi), 32'd1);
    drain();

    // Flag boundaries: wide all-zero, narrow ignores in_hi, narrow MSB set
    push_res(32'h0, 32'h0, 1'b1, 4'd7, 1'b1, 1'b0, w);
    push_res(32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 4'd1, 1'b0, 1'b0, w);
    push_res(32'h8000_0000, 32'h0, 1'b0, 4'd2, 1'b0, 1'b1, w);
    drain();

    // Backpressure: third result must wait for the first pop
    out_ready = 1'b0;
    push_res(32'h1, 32'h0, 1'b0, 4'd1, 1'b0, 1'b0, w);
    push_res(32'h2, 32'h0, 1'b0, 4'd1, 1'b0, 1'b0, w);
    @(negedge clk);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("hold_data", out_data, 32'h1);
    @(posedge clk); #1;
    chk("hold_data_again", out_data, 32'h1);
    out_ready = 1'b1;
    push_res(32'h3, 32'h0, 1'b0, 4'd1, 1'b0, 1'b0, w);
    chk("third_accept_waits", 32'(w), 32'd1);
    drain();

    // Simultaneous push and pop with one entry held
    push_res(32'hA, 32'h0, 1'b0, 4'd4, 1'b0, 1'b0, w);
    push_res(32'hB, 32'h0, 1'b0, 4'd4, 1'b0, 1'b0, w);
    chk("pushpop_no_wait", 32'(w), 32'd0);
    chk("pushpop_valid", 32'(out_valid), 32'd1);
    chk("pushpop_data", out_data, 32'hB);
    push_res(32'hFFFF_FFFF, 32'h0, 1'b0, 4'd4, 1'b0, 1'b1, w);
    chk("pushpop_ready", 32'(in_ready), 32'd1);
    drain();

    // Reset after the ZLo beat of a wide result
    push_res(32'h0000_0002, 32'h0000_0001, 1'b1, 4'd6, 1'b0, 1'b0, w);
    @(posedge clk); #1;
    chk("pre_reset_beat_hi", 32'(out_hi), 32'd1);
    clr_n = 1'b0;
    sb.delete();
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", out_data, 32'd0);
    chk("async_rst_flags", 32'({out_last, out_hi, out_zero, out_neg, out_op}), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); @(posedge clk); #1;
    clr_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    push_res(32'h0000_0077, 32'h0, 1'b0, 4'd9, 1'b0, 1'b0, w);
    chk("post_rst_lo_beat", out_data, 32'h77);
    chk("post_rst_beat_hi", 32'(out_hi), 32'd0);
    drain();

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
